// File: rtl/rr_mux_reg_pkg.sv
// ---------------------------------------------------------------------------
// rr_mux_reg_pkg
// Shared definitions for the registered round-robin selection mux.
//   MODE_RR / MODE_FIXED : encodings of the 'mode' input
//   out_state_e          : state of the single output register
//   wrap_inc             : index increment that wraps at n-1 back to 0
// ---------------------------------------------------------------------------
package rr_mux_reg_pkg;

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    // Wraps explicitly at n-1 so non-power-of-two channel counts never
    // step into unused index encodings.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_mux_reg_arbiter.sv
// ---------------------------------------------------------------------------
// rr_mux_reg_arbiter
// Purely combinational round-robin arbiter. It searches the request vector
// starting at 'ptr' and wrapping modulo NUM_IN, and grants the first
// requester found.
//   req   [NUM_IN-1:0] : per-channel request
//   ptr   [SEL_W-1:0]  : channel with highest priority this cycle
//   grant [NUM_IN-1:0] : one-hot grant, all zero when nothing requests
//   index [SEL_W-1:0]  : encoded index of the granted channel (0 if none)
// ---------------------------------------------------------------------------
module rr_mux_reg_arbiter
    import rr_mux_reg_pkg::*;
#(
    parameter  int NUM_IN = 8,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [NUM_IN-1:0] grant,
    output logic [SEL_W-1:0]  index
);

    // Walk the channels once, starting at the pointer. The 'found' flag
    // freezes the result on the first hit so later requesters are ignored.
    // A pointer outside 0..NUM_IN-1 cannot come from the top module, but
    // is folded back to 0 so the search stays in range.
    always_comb begin
        int  idx;
        logic found;
        grant = '0;
        index = '0;
        found = 1'b0;
        idx   = (int'(ptr) < NUM_IN) ? int'(ptr) : 0;
        for (int step = 0; step < NUM_IN; step++) begin
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                index      = SEL_W'(idx);
            end
            idx = wrap_inc(idx, NUM_IN);
        end
    end

endmodule

// File: rtl/rr_mux_reg.sv
// ---------------------------------------------------------------------------
// rr_mux_reg
// Parametrised N-input registered selection mux with valid/ready handshakes
// on every input channel and on the output. It selects one requesting
// channel, either round-robin or by a fixed select, captures that channel's
// data into one output register, and presents the data with its source tag.
//
// Ports:
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous reset, active low
//   in_data    : flattened inputs, channel i at [i*WIDTH +: WIDTH]
//   in_valid   : per-channel request
//   in_ready   : per-channel accept (combinational, at most one bit set)
//   mode       : 0 = round-robin, 1 = fixed select via 'sel'
//   sel        : channel used in fixed mode; values >= NUM_IN select nothing
//   out_data   : registered selected data
//   out_src    : registered index of the channel that produced out_data
//   out_valid  : output register holds valid data
//   out_ready  : downstream accept
// ---------------------------------------------------------------------------
module rr_mux_reg
    import rr_mux_reg_pkg::*;
#(
    parameter  int WIDTH  = 64,
    parameter  int NUM_IN = 8,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_IN*WIDTH-1:0]   in_data,
    input  logic [NUM_IN-1:0]         in_valid,
    output logic [NUM_IN-1:0]         in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_src,
    output logic                      out_valid,
    input  logic                      out_ready
);

    out_state_e          state;
    logic [SEL_W-1:0]    rr_ptr;

    logic                load_en;
    logic [NUM_IN-1:0]   rr_grant;
    logic [SEL_W-1:0]    rr_index;
    logic [NUM_IN-1:0]   fixed_grant;
    logic [NUM_IN-1:0]   grant;
    logic [SEL_W-1:0]    win_idx;
    logic                transfer;
    logic [WIDTH-1:0]    chan [NUM_IN];
    logic [WIDTH-1:0]    win_data;

    // Unpack the flattened input bus so the winner can be picked by index.
    for (genvar g = 0; g < NUM_IN; g++) begin : g_unpack
        assign chan[g] = in_data[g*WIDTH +: WIDTH];
    end

    rr_mux_reg_arbiter #(
        .NUM_IN (NUM_IN)
    ) u_arbiter (
        .req   (in_valid),
        .ptr   (rr_ptr),
        .grant (rr_grant),
        .index (rr_index)
    );

    assign out_valid = (state == OUT_FULL);

    // The register can take a new word when empty, or when full and the
    // downstream side drains it in the same cycle.
    assign load_en = !out_valid || out_ready;

    // Fixed-select grant: only an in-range select whose channel is
    // requesting wins; out-of-range selects simply produce no grant.
    always_comb begin
        fixed_grant = '0;
        if (int'(sel) < NUM_IN) begin
            if (in_valid[sel]) begin
                fixed_grant[sel] = 1'b1;
            end
        end
    end

    // Mode picks which grant source is live. Because this is evaluated
    // every cycle, a mode or select change applies to the very next grant.
    always_comb begin
        grant   = rr_grant;
        win_idx = rr_index;
        if (mode == MODE_FIXED) begin
            grant   = fixed_grant;
            win_idx = sel;
        end
    end

    // No channel is accepted during reset, so a word offered in a reset
    // cycle is never consumed.
    assign in_ready = (rst && load_en) ? grant : '0;
    assign transfer = |in_ready;
    assign win_data = chan[win_idx];

    // Output register FSM and round-robin pointer. A transfer loads the
    // word and tag; a load opportunity without a winner empties the
    // register while leaving stale data/tag behind; a stalled full register
    // holds everything. Only round-robin transfers advance the pointer, to
    // the channel after the winner.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= OUT_EMPTY;
            out_data <= '0;
            out_src  <= '0;
            rr_ptr   <= '0;
        end else if (load_en) begin
            if (transfer) begin
                state    <= OUT_FULL;
                out_data <= win_data;
                out_src  <= win_idx;
                if (mode == MODE_RR) begin
                    rr_ptr <= SEL_W'(wrap_inc(int'(win_idx), NUM_IN));
                end
            end else begin
                state <= OUT_EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_rr_mux_reg.sv
// ---------------------------------------------------------------------------
// tb_rr_mux_reg
// Self-checking bench for rr_mux_reg. An 8-input instance is driven through
// directed steps while a reference model predicts the grant and pushes the
// expected word into a scoreboard queue; the head is compared while the
// output register is full and popped when it drains. A second 5-input
// instance covers select values beyond NUM_IN and pointer wrap at NUM_IN-1.
// ---------------------------------------------------------------------------
module tb_rr_mux_reg;

    typedef struct {
        logic [63:0] data;
        logic [2:0]  src;
    } sb_entry_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [511:0] in_data;
    logic [7:0]   in_valid;
    logic [7:0]   in_ready;
    logic         mode;
    logic [2:0]   sel;
    logic [63:0]  out_data;
    logic [2:0]   out_src;
    logic         out_valid;
    logic         out_ready;

    logic [319:0] in_data5;
    logic [4:0]   in_valid5;
    logic [4:0]   in_ready5;
    logic         mode5;
    logic [2:0]   sel5;
    logic [63:0]  out_data5;
    logic [2:0]   out_src5;
    logic         out_valid5;

    int           checks   = 0;
    int           failures = 0;

    sb_entry_t    sb[$];
    logic         m_full;
    int           m_ptr;

    rr_mux_reg #(
        .WIDTH  (64),
        .NUM_IN (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    rr_mux_reg #(
        .WIDTH  (64),
        .NUM_IN (5)
    ) dut5 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data5),
        .in_valid  (in_valid5),
        .in_ready  (in_ready5),
        .mode      (mode5),
        .sel       (sel5),
        .out_data  (out_data5),
        .out_src   (out_src5),
        .out_valid (out_valid5),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Watchdog so the run always ends even if something stalls the sequence.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic m, input logic [2:0] s,
                                 input logic [7:0] v, input logic ordy);
        mode      = m;
        sel       = s;
        in_valid  = v;
        out_ready = ordy;
    endtask

    // Reference grant decision for the 8-input instance: -1 means no grant.
    function automatic int modelWinner();
        int c;
        if (rst == 1'b0) return -1;
        if (mode == 1'b1) return in_valid[sel] ? int'(sel) : -1;
        for (int k = 0; k < 8; k++) begin
            c = (m_ptr + k) % 8;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    // One clock step: check in_ready before the edge, advance the model and
    // scoreboard at the edge, then check the registered outputs after it.
    task automatic tick();
        int         w;
        logic       le;
        logic [7:0] exp_ready;
        #1;
        le        = !m_full || out_ready;
        w         = modelWinner();
        exp_ready = (le && w >= 0) ? (8'b1 << w) : 8'b0;
        checkOutput("in_ready", 64'(in_ready), 64'(exp_ready));
        @(posedge clk);
        if (!rst) begin
            sb.delete();
            m_full = 1'b0;
            m_ptr  = 0;
        end else if (le) begin
            if (m_full) void'(sb.pop_front());
            if (w >= 0) begin
                sb.push_back('{data: in_data[w*64 +: 64], src: 3'(w)});
                m_full = 1'b1;
                if (mode == 1'b0) m_ptr = (w == 7) ? 0 : w + 1;
            end else begin
                m_full = 1'b0;
            end
        end
        #1;
        checkOutput("out_valid", 64'(out_valid), 64'(m_full));
        if (m_full) begin
            checkOutput("out_data", out_data, sb[0].data);
            checkOutput("out_src", 64'(out_src), 64'(sb[0].src));
        end
        checkOutput("rr_ptr", 64'(dut.rr_ptr), 64'(m_ptr));
    endtask

    task automatic doReset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        logic [3:0] nib;
        int         exp5_src [6] = '{0, 1, 2, 3, 4, 0};
        int         exp5_ptr [6] = '{1, 2, 3, 4, 0, 1};

        $display("[TB] start");
        rst = 1'b0;
        m_full = 1'b0;
        m_ptr  = 0;
        for (int i = 0; i < 8; i++) begin
            nib = i[3:0];
            in_data[i*64 +: 64] = {16{nib}};
        end
        for (int i = 0; i < 5; i++) begin
            nib = 4'(i + 10);
            in_data5[i*64 +: 64] = {16{nib}};
        end
        in_valid5 = 5'h1F;
        mode5     = 1'b1;
        sel5      = 3'd7;
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b1);

        // Reset state
        doReset();
        checkOutput("reset_out_data", out_data, 64'h0);
        checkOutput("reset_out_src", 64'(out_src), 64'h0);
        checkOutput("reset_out_valid", 64'(out_valid), 64'h0);

        // Fixed select sweep
        for (int s = 0; s < 8; s++) begin
            applyStimulus(1'b1, 3'(s), 8'hFF, 1'b1);
            tick();
        end

        // Round-robin fairness from a fresh reset
        doReset();
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1'b0, 3'd0, 8'hFF, 1'b1);
            tick();
            checkOutput("rr_seq_src", 64'(out_src), 64'(c % 8));
        end

        // Sparse requests with pointer wrap
        doReset();
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b0, 3'd0, 8'b0100_0100, 1'b1);
            tick();
        end

        // Backpressure: first load, four stalled cycles, then drain
        doReset();
        applyStimulus(1'b0, 3'd0, 8'hFF, 1'b0);
        tick();
        for (int c = 0; c < 4; c++) tick();
        checkOutput("stall_src", 64'(out_src), 64'h0);
        applyStimulus(1'b0, 3'd0, 8'hFF, 1'b1);
        tick();
        checkOutput("after_stall_src", 64'(out_src), 64'h1);

        // Selected channel not requesting: register drains and empties
        applyStimulus(1'b1, 3'd3, 8'b1111_0111, 1'b1);
        tick();
        tick();

        // 5-input build: out-of-range select grants nothing
        mode5 = 1'b1;
        sel5  = 3'd7;
        #1;
        checkOutput("n5_sel7_ready", 64'(in_ready5), 64'h0);
        tick();
        checkOutput("n5_sel7_valid", 64'(out_valid5), 64'h0);
        sel5 = 3'd5;
        #1;
        checkOutput("n5_sel5_ready", 64'(in_ready5), 64'h0);
        tick();

        // 5-input build: round-robin wraps at channel 4
        doReset();
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b1);
        mode5 = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            nib = 4'(exp5_src[c] + 10);
            checkOutput("n5_rr_valid", 64'(out_valid5), 64'h1);
            checkOutput("n5_rr_src", 64'(out_src5), 64'(exp5_src[c]));
            checkOutput("n5_rr_data", out_data5, {16{nib}});
            checkOutput("n5_rr_ptr", 64'(dut5.rr_ptr), 64'(exp5_ptr[c]));
        end
        mode5 = 1'b1;
        sel5  = 3'd7;

        // Reset while full discards the held word; round-robin restarts at 0
        doReset();
        applyStimulus(1'b0, 3'd0, 8'hFF, 1'b1);
        tick();
        applyStimulus(1'b1, 3'd5, 8'hFF, 1'b1);
        tick();
        checkOutput("pre_reset_data", out_data, 64'h5555_5555_5555_5555);
        applyStimulus(1'b1, 3'd5, 8'hFF, 1'b0);
        rst = 1'b0;
        tick();
        checkOutput("mid_reset_data", out_data, 64'h0);
        checkOutput("mid_reset_src", 64'(out_src), 64'h0);
        checkOutput("mid_reset_valid", 64'(out_valid), 64'h0);
        rst = 1'b1;
        applyStimulus(1'b0, 3'd0, 8'hFF, 1'b1);
        tick();
        checkOutput("post_reset_src", 64'(out_src), 64'h0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
